// File: rtl/pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pkt_pkg
// Description : Shared types and default widths for the packet field
//               extraction slice.
// Revision    : 1.0 - initial release
// ============================================================================
package pkt_pkg;

   localparam int PKT_DATA_W  = 64;
   localparam int PKT_FIELD_W = 32;
   localparam int PKT_OFF_W   = 16;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_HOLD    = 2'd2,
      S_SKIP    = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/beat_slicer.sv
`default_nettype none
// ============================================================================
// Module      : beat_slicer
// Description : Combinational mask/shift: returns the bits of the current
//               beat that fall inside [offset, offset+len-1], already aligned
//               to field bit 0, plus a flag that the field ends by this beat.
// Revision    : 1.0 - initial release
// ============================================================================
module beat_slicer
   import pkt_pkg::*;
#(
   parameter int DATA_W  = PKT_DATA_W,
   parameter int FIELD_W = PKT_FIELD_W,
   parameter int OFF_W   = PKT_OFF_W,
   parameter int CNT_W   = PKT_OFF_W + 1
) (
   input  logic [CNT_W-1:0]               beat_idx,
   input  logic [OFF_W-1:0]               offset,
   input  logic [$clog2(FIELD_W+1)-1:0]   len,
   input  logic [DATA_W-1:0]              data,
   output logic [FIELD_W-1:0]             bits,
   output logic                           done
);

   localparam int LEN_W = $clog2(FIELD_W+1);
   localparam int IDX_W = $clog2(DATA_W);
   // Wide enough for beat_idx*DATA_W + DATA_W and offset+FIELD_W without wrap
   localparam int PW    = ((CNT_W + IDX_W) > (OFF_W + 1) ? (CNT_W + IDX_W) : (OFF_W + 1)) + 2;

   logic [PW-1:0] w_base;
   logic [PW-1:0] w_end;

   assign w_base = PW'(beat_idx) * PW'(DATA_W);
   assign w_end  = PW'(offset) + PW'(len);
   // Field complete once its last bit index is below the end of this beat
   assign done   = (w_end <= (w_base + PW'(DATA_W)));

   genvar i;
   generate
      for (i = 0; i < FIELD_W; i++) begin : g_bit
         logic [PW-1:0] w_pos;
         logic [PW-1:0] w_rel;
         logic          w_in;
         assign w_pos = PW'(offset) + PW'(i);
         assign w_rel = w_pos - w_base;
         assign w_in  = (LEN_W'(i) < len) && (w_pos >= w_base) && (w_rel < PW'(DATA_W));
         assign bits[i] = w_in ? data[w_rel[IDX_W-1:0]] : 1'b0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/field_extractor.sv
`default_nettype none
// ============================================================================
// Module      : field_extractor
// Description : Extracts a bit field [offset, offset+len-1] from an LSB-first
//               packet beat stream and presents it right-aligned on a
//               valid/ready output, flagging packets that end too early.
// Revision    : 1.0 - initial release
// ============================================================================
module field_extractor
   import pkt_pkg::*;
#(
   parameter int DATA_W  = PKT_DATA_W,
   parameter int FIELD_W = PKT_FIELD_W,
   parameter int OFF_W   = PKT_OFF_W
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [OFF_W-1:0]               cfg_offset,
   input  logic [$clog2(FIELD_W+1)-1:0]   cfg_len,
   input  logic [DATA_W-1:0]              in_data,
   input  logic                           in_valid,
   input  logic                           in_last,
   output logic                           in_ready,
   output logic [FIELD_W-1:0]             field_data,
   output logic                           field_err,
   output logic                           field_valid,
   input  logic                           field_ready
);

   localparam int LEN_W = $clog2(FIELD_W+1);
   // One extra bit past the offset range keeps offset+len reachable
   localparam int CNT_W = OFF_W + 1;
   localparam logic [LEN_W-1:0] C_FULL_LEN = LEN_W'(FIELD_W);
   localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

   state_t             r_state,     w_state_nx;
   logic [CNT_W-1:0]   r_cnt,       w_cnt_nx;
   logic [OFF_W-1:0]   r_off,       w_off_nx;
   logic [LEN_W-1:0]   r_len,       w_len_nx;
   logic [FIELD_W-1:0] r_data,      w_data_nx;
   logic               r_err,       w_err_nx;
   logic               r_last_seen, w_last_nx;

   logic               w_acc;
   logic               w_sat;
   logic [LEN_W-1:0]   w_len_cfg;
   logic [CNT_W-1:0]   w_sl_idx;
   logic [OFF_W-1:0]   w_sl_off;
   logic [LEN_W-1:0]   w_sl_len;
   logic [FIELD_W-1:0] w_bits;
   logic               w_done;

   assign in_ready    = (r_state != S_HOLD);
   assign w_acc       = in_valid && in_ready;
   assign w_sat       = (r_cnt == C_CNT_MAX);
   assign w_len_cfg   = ((cfg_len == '0) || (cfg_len > C_FULL_LEN)) ? C_FULL_LEN : cfg_len;

   // The first beat slices with live config; later beats use the sampled copy
   assign w_sl_idx    = (r_state == S_CAPTURE) ? r_cnt : '0;
   assign w_sl_off    = (r_state == S_IDLE) ? cfg_offset : r_off;
   assign w_sl_len    = (r_state == S_IDLE) ? w_len_cfg  : r_len;

   assign field_data  = r_data;
   assign field_err   = r_err;
   assign field_valid = (r_state == S_HOLD);

   beat_slicer #(
      .DATA_W  (DATA_W),
      .FIELD_W (FIELD_W),
      .OFF_W   (OFF_W),
      .CNT_W   (CNT_W)
   ) u_slicer (
      .beat_idx (w_sl_idx),
      .offset   (w_sl_off),
      .len      (w_sl_len),
      .data     (in_data),
      .bits     (w_bits),
      .done     (w_done)
   );

   // Next-state and datapath update for the extraction FSM
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_off_nx   = r_off;
      w_len_nx   = r_len;
      w_data_nx  = r_data;
      w_err_nx   = r_err;
      w_last_nx  = r_last_seen;
      case (r_state)
         S_IDLE: begin
            if (w_acc) begin
               w_data_nx = w_bits;
               w_off_nx  = cfg_offset;
               w_len_nx  = w_len_cfg;
               w_cnt_nx  = CNT_W'(1);
               if (w_done) begin
                  w_state_nx = S_HOLD;
                  w_err_nx   = 1'b0;
                  w_last_nx  = in_last;
               end else if (in_last) begin
                  w_state_nx = S_HOLD;
                  w_err_nx   = 1'b1;
                  w_last_nx  = 1'b1;
               end else begin
                  w_state_nx = S_CAPTURE;
               end
            end
         end
         S_CAPTURE: begin
            if (w_acc) begin
               // A saturated counter means the beat lies beyond any field
               if (!w_sat) begin
                  w_data_nx = r_data | w_bits;
                  w_cnt_nx  = r_cnt + CNT_W'(1);
               end
               if (w_done && !w_sat) begin
                  w_state_nx = S_HOLD;
                  w_err_nx   = 1'b0;
                  w_last_nx  = in_last;
               end else if (in_last) begin
                  w_state_nx = S_HOLD;
                  w_err_nx   = 1'b1;
                  w_last_nx  = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (field_ready) begin
               w_state_nx = r_last_seen ? S_IDLE : S_SKIP;
               w_cnt_nx   = '0;
            end
         end
         S_SKIP: begin
            if (w_acc && in_last) begin
               w_state_nx = S_IDLE;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any packet in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_off       <= '0;
         r_len       <= '0;
         r_data      <= '0;
         r_err       <= 1'b0;
         r_last_seen <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_cnt       <= w_cnt_nx;
         r_off       <= w_off_nx;
         r_len       <= w_len_nx;
         r_data      <= w_data_nx;
         r_err       <= w_err_nx;
         r_last_seen <= w_last_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_field_extractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_field_extractor
// Description : Directed self-checking bench for field_extractor
//               (DATA_W=64, FIELD_W=32, OFF_W=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_field_extractor;

   logic        clk;
   logic        rst_n;
   logic [15:0] cfg_offset;
   logic [5:0]  cfg_len;
   logic [63:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [31:0] field_data;
   logic        field_err;
   logic        field_valid;
   logic        field_ready;

   int n_checks;
   int n_fail;

   field_extractor #(
      .DATA_W  (64),
      .FIELD_W (32),
      .OFF_W   (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_offset  (cfg_offset),
      .cfg_len     (cfg_len),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .field_data  (field_data),
      .field_err   (field_err),
      .field_valid (field_valid),
      .field_ready (field_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one beat and return #1 after the edge that accepted it
   task automatic send_beat(input logic [63:0] d, input logic last);
      int waited;
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      waited   = 0;
      while (!in_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) check("beat_accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Complete the output handshake for one cycle
   task automatic take_field();
      field_ready = 1'b1;
      @(posedge clk); #1;
      field_ready = 1'b0;
   endtask

   task automatic expect_field(input string tag, input logic [31:0] d, input logic e);
      check({tag, "_valid"}, {63'd0, field_valid}, 64'd1);
      check({tag, "_data"},  {32'd0, field_data},  {32'd0, d});
      check({tag, "_err"},   {63'd0, field_err},   {63'd0, e});
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      cfg_offset  = '0;
      cfg_len     = '0;
      in_data     = '0;
      in_valid    = 1'b0;
      in_last     = 1'b0;
      field_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {63'd0, field_valid}, 64'd0);
      check("rst_err",   {63'd0, field_err},   64'd0);
      check("rst_data",  {32'd0, field_data},  64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Field within one beat, surrounding bits all ones
      cfg_offset = 16'd8;
      cfg_len    = 6'd16;
      send_beat(64'hFFFF_FFFF_FFAB_CDFF, 1'b0);
      expect_field("t1", 32'h0000_ABCD, 1'b0);
      check("t1_hold_ready", {63'd0, in_ready}, 64'd0);
      take_field();
      check("t1_skip_valid", {63'd0, field_valid}, 64'd0);
      check("t1_skip_ready", {63'd0, in_ready}, 64'd1);
      send_beat(64'h1234_5678_9ABC_DEF0, 1'b1);

      // Field spanning a beat boundary
      cfg_offset = 16'd56;
      cfg_len    = 6'd16;
      send_beat(64'h1211_1111_1111_1111, 1'b0);
      check("t2_mid_valid", {63'd0, field_valid}, 64'd0);
      send_beat(64'hFFFF_FFFF_FFFF_FF34, 1'b1);
      expect_field("t2", 32'h0000_3412, 1'b0);
      take_field();
      check("t2_idle_ready", {63'd0, in_ready}, 64'd1);

      // Packet too short for the field
      cfg_offset = 16'd100;
      cfg_len    = 6'd32;
      send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      expect_field("t3", 32'h0000_0000, 1'b1);
      take_field();

      // len=0 and len>FIELD_W both mean a full-width field
      cfg_offset = 16'd0;
      cfg_len    = 6'd0;
      send_beat(64'hDEAD_BEEF_CAFE_F00D, 1'b1);
      expect_field("len0", 32'hCAFE_F00D, 1'b0);
      take_field();
      cfg_offset = 16'd16;
      cfg_len    = 6'd40;
      send_beat(64'h0123_4567_89AB_CDEF, 1'b1);
      expect_field("len40", 32'h4567_89AB, 1'b0);
      take_field();

      // Back-pressure: output stalls, next beat waits, data stays put
      cfg_offset = 16'd4;
      cfg_len    = 6'd8;
      send_beat(64'h0000_0000_0000_0A50, 1'b0);
      expect_field("t4a", 32'h0000_00A5, 1'b0);
      in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      in_last  = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("t4_stall_ready", {63'd0, in_ready},    64'd0);
         check("t4_stall_valid", {63'd0, field_valid}, 64'd1);
         check("t4_stall_data",  {32'd0, field_data},  64'h0000_00A5);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      take_field();
      send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      cfg_offset = 16'd60;
      cfg_len    = 6'd8;
      send_beat(64'hB000_0000_0000_0000, 1'b0);
      send_beat(64'h0000_0000_0000_0007, 1'b1);
      expect_field("t4b", 32'h0000_007B, 1'b0);
      take_field();

      // Reset during beat 1 of a 3-beat packet
      cfg_offset = 16'd60;
      cfg_len    = 6'd16;
      send_beat(64'hF000_0000_0000_0000, 1'b0);
      in_data  = 64'h0000_0000_0000_0FFF;
      in_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_valid", {63'd0, field_valid}, 64'd0);
      check("t5_rst_err",   {63'd0, field_err},   64'd0);
      check("t5_rst_data",  {32'd0, field_data},  64'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("t5_in_ready", {63'd0, in_ready}, 64'd1);
      cfg_offset = 16'd0;
      cfg_len    = 6'd8;
      send_beat(64'h0000_0000_0000_005A, 1'b1);
      expect_field("t5", 32'h0000_005A, 1'b0);
      take_field();

      // Config changes after the first beat must not affect the field
      cfg_offset = 16'd60;
      cfg_len    = 6'd8;
      send_beat(64'hC000_0000_0000_0000, 1'b0);
      cfg_offset = 16'd0;
      cfg_len    = 6'd4;
      send_beat(64'h0000_0000_0000_00F3, 1'b1);
      expect_field("t6", 32'h0000_003C, 1'b0);
      take_field();
      check("t6_idle_ready", {63'd0, in_ready}, 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/field_extractor.md
FIELD_EXTRACTOR -- requirements
Module: field_extractor

Interface
REQ-001 SHALL have parameter DATA_W, default 64: beat width in bits of the inbound packet stream.
REQ-002 SHALL have parameter FIELD_W, default 32: maximum extracted field width in bits.
REQ-003 SHALL have parameter OFF_W, default 16: width of the bit-offset configuration input.
REQ-004 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port cfg_offset, input, OFF_W: bit index of the first field bit, counted from packet bit 0.
REQ-007 SHALL have port cfg_len, input, $clog2(FIELD_W+1): field length in bits, 1..FIELD_W.
REQ-008 SHALL have ports in_data (input, DATA_W), in_valid (input, 1), in_last (input, 1) and in_ready (output, 1): packet beat stream.
REQ-009 SHALL have ports field_data (output, FIELD_W), field_err (output, 1), field_valid (output, 1) and field_ready (input, 1): extracted-field stream.

Function
REQ-010 SHALL number packet bits LSB-first: beat k, bit j is packet bit k*DATA_W+j.
REQ-011 SHALL sample cfg_offset and cfg_len on the first accepted beat of each packet and ignore them until that packet's in_last beat is accepted.
REQ-012 SHALL treat cfg_len=0 or cfg_len>FIELD_W as FIELD_W.
REQ-013 SHALL implement the states IDLE, CAPTURE, HOLD and SKIP.
REQ-014 SHALL transfer a beat only when in_valid and in_ready are both 1 on the same edge.
REQ-015 SHALL drive in_ready=1 in IDLE, CAPTURE and SKIP, and in_ready=0 in HOLD.
REQ-016 SHALL, in IDLE and CAPTURE, copy every accepted bit whose packet index lies in [offset, offset+len-1] into field_data bit (index - offset).
REQ-017 SHALL support a field that spans any number of beats, including a field that starts and ends within one beat.
REQ-018 SHALL leave a field's bits outside [0, len-1] as zero; the output field is right-aligned and zero-extended.
REQ-019 SHALL enter HOLD, asserting field_valid with field_err=0 on the next cycle, once the beat holding the last field bit is accepted.
REQ-020 SHALL have an output latency of exactly 1 cycle from that beat's acceptance.
REQ-021 SHALL, when in_last is accepted before the field is complete, enter HOLD with field_err=1 and field_data holding the partial bits captured so far.
REQ-022 SHALL, when field_valid and field_ready are both 1 in HOLD, go to IDLE if in_last was already accepted, otherwise to SKIP.
REQ-023 SHALL hold field_data, field_err and field_valid stable in HOLD until field_ready is 1.
REQ-024 SHALL, in SKIP, discard beats until in_last is accepted, then go to IDLE.
REQ-025 SHALL treat a single-beat packet (in_last on the first beat) correctly: complete or err, then IDLE after the handshake.
REQ-026 SHALL keep the running beat counter wide enough for offset+len without wrap; once the counter saturates, beats are discarded.

Reset
REQ-027 SHALL, while rst_n=0, force state=IDLE, field_valid=0, field_err=0, field_data=0 and beat count=0, and drive in_ready=1 once rst_n=1.
REQ-028 SHALL, on reset mid-packet, abandon the packet; the next accepted beat is treated as a first beat.

Structure
REQ-029 SHALL place the state enum and the default DATA_W/FIELD_W/OFF_W constants in shared package pkt_pkg.
REQ-030 SHALL use one sub-module, beat_slicer: a combinational mask/shift that, from beat index, offset and len, returns the bits of the current beat that fall inside the field, already aligned.

Verification (DATA_W=64, FIELD_W=32)
REQ-031 SHALL cover: offset=8, len=16, 2-beat packet, beat0=0x...00ABCD00 -> field_data=0x0000ABCD, err=0, 1 cycle after beat0, then SKIP consumes beat1.
REQ-032 SHALL cover: offset=56, len=16, beat0[63:56]=0x12, beat1[7:0]=0x34 -> field_data=0x3412 after beat1.
REQ-033 SHALL cover: offset=100, len=32, 1-beat packet -> field_err=1, field_data=0.
REQ-034 SHALL cover: field_ready held 0 for 5 cycles -> in_ready=0 and field_data stable throughout; a back-to-back second packet is extracted correctly afterwards.
REQ-035 SHALL cover: rst_n pulsed low during beat 1 of a 3-beat packet -> outputs return to reset values; a fresh packet afterwards yields the correct field.
REQ-036 SHALL cover: cfg_offset changed mid-packet -> no effect on the current field.
